// File: rtl/mem_arbiter_pkg.sv
// Shared pipeline types for the memory-port arbiter: FSM states, the NOP word
// and the registered memory-request bundle.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2
  } arb_state_t;

  // addi x0, x0, 0 -- a hung fetch decodes as a harmless NOP
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-input round-robin picker: a lone requester always wins, a tie goes to
// the input that was not granted last.
module rr_pick2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;  // index of the most recently granted input

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b0;
    else if (advance && (req != 2'b00))
      last <= grant[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with
// round-robin arbitration and a wait-state watchdog that ends hung accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          MAX_WAIT  = 16,
  parameter logic [31:0] ERR_RDATA = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_valid,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  localparam int              CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   WAIT_SAT = CW'(MAX_WAIT);
  localparam logic [CW-1:0]   WAIT_TO  = CW'(MAX_WAIT - 1);

  arb_state_t    state;
  mem_req_t      req_q;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    grant;
  logic          busy;
  logic          timeout;
  logic          timed_out;
  logic          done;
  logic [31:0]   resp_data;

  rr_pick2 u_pick (
    .clk     (clk),
    .rst     (rst),
    .req     ({d_valid, if_valid}),
    .advance (state == ARB_IDLE),
    .grant   (grant)
  );

  // The counter holds the number of stalled cycles already spent, so the
  // watchdog trips during the MAX_WAIT-th busy cycle.
  assign busy      = (state != ARB_IDLE);
  assign timeout   = (wait_cnt >= WAIT_TO);
  assign timed_out = busy && timeout && !mem_ready;
  assign done      = busy && (mem_ready || timeout);
  assign resp_data = timed_out ? ERR_RDATA : mem_rdata;

  // Completion is combinational for single-cycle latency; reset masks it so
  // an abandoned access never reports.
  assign if_ready  = !rst && done && (state == ARB_BUSY_IF);
  assign d_ready   = !rst && done && (state == ARB_BUSY_D);
  assign err       = !rst && timed_out;
  assign if_rdata  = if_ready ? resp_data : '0;
  assign d_rdata   = d_ready  ? resp_data : '0;

  assign mem_we    = req_q.we;
  assign mem_wstrb = req_q.wstrb;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      req_q     <= '0;
      mem_valid <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant[1]) begin
            state     <= ARB_BUSY_D;
            req_q     <= '{we: d_we, wstrb: d_wstrb, addr: d_addr, wdata: d_wdata};
            mem_valid <= 1'b1;
            wait_cnt  <= '0;
          end else if (grant[0]) begin
            state     <= ARB_BUSY_IF;
            req_q     <= '{we: 1'b0, wstrb: 4'b0000, addr: if_addr, wdata: 32'h0};
            mem_valid <= 1'b1;
            wait_cnt  <= '0;
          end
        end
        ARB_BUSY_IF, ARB_BUSY_D: begin
          if (done) begin
            state     <= ARB_IDLE;
            mem_valid <= 1'b0;
          end else if (wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ARB_IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// model: winner by round-robin rule, completion at min(latency+1, MAX_WAIT).
module tb_mem_arbiter;

  localparam int          MAX_WAIT = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_valid;
  logic        d_we;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.MAX_WAIT(MAX_WAIT), .ERR_RDATA(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .d_valid   (d_valid),
    .d_we      (d_we),
    .d_wstrb   (d_wstrb),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_wstrb (mem_wstrb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " mem_valid"}, mem_valid, 0);
    check({tag, " if_ready"}, if_ready, 0);
    check({tag, " d_ready"}, d_ready, 0);
    check({tag, " err"}, err, 0);
  endtask

  // Called just after the grant edge. The memory answers after `lat` wait
  // states; the expected finish is the earlier of that and the watchdog.
  // Returns in the following idle cycle with the winner's request dropped.
  task automatic serve(input int lat, input bit win_d, input logic [31:0] rd, input bit late);
    logic [31:0] ea;
    logic        ewe;
    logic [3:0]  es;
    logic [31:0] ew;
    bit          done;
    bit          to;
    ea   = win_d ? d_addr : if_addr;
    ewe  = win_d ? d_we : 1'b0;
    es   = win_d ? d_wstrb : 4'b0000;
    ew   = d_wdata;
    done = 1'b0;
    for (int k = 1; k <= MAX_WAIT && !done; k++) begin
      mem_ready = (k - 1 == lat);
      mem_rdata = mem_ready ? rd : $urandom;
      #1;
      check("busy mem_valid", mem_valid, 1);
      check("busy mem_addr", mem_addr, ea);
      check("busy mem_we", mem_we, ewe);
      check("busy mem_wstrb", mem_wstrb, es);
      if (win_d) check("busy mem_wdata", mem_wdata, ew);
      to   = (k == MAX_WAIT) && !mem_ready;
      done = mem_ready || to;
      check("if_ready", if_ready, !win_d && done);
      check("d_ready", d_ready, win_d && done);
      check("err", err, to);
      if (done) begin
        if (win_d) check("d_rdata", d_rdata, to ? NOP : rd);
        else       check("if_rdata", if_rdata, to ? NOP : rd);
      end else begin
        next_cycle();
      end
    end
    next_cycle();
    if (win_d) d_valid = 1'b0;
    else       if_valid = 1'b0;
    mem_ready = late;
    mem_rdata = $urandom;
    #1;
    check_idle("post");
  endtask

  initial begin
    bit last_d;
    bit win_d;

    rst = 1'b1;
    if_valid = 1'b0; if_addr = '0;
    d_valid = 1'b0; d_we = 1'b0; d_wstrb = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    check_idle("reset");
    check("reset mem_we", mem_we, 0);
    check("reset mem_wstrb", mem_wstrb, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset if_rdata", if_rdata, 0);
    check("reset d_rdata", d_rdata, 0);

    // Fetch only, zero-wait memory
    rst = 1'b0;
    if_valid = 1'b1; if_addr = 32'h100;
    #1;
    check("fetch pre-grant mem_valid", mem_valid, 0);
    next_cycle();
    serve(0, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Continuous contention: data, fetch, data, fetch
    if_valid = 1'b1; if_addr = 32'h200;
    d_valid = 1'b1; d_we = 1'b0; d_wstrb = 4'b1111; d_addr = 32'h300; d_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      serve(0, (i % 2) == 0, 32'h1000 + i, 1'b0);
      if_valid = 1'b1;
      d_valid = 1'b1;
    end
    if_valid = 1'b0;
    d_valid = 1'b0;

    // Store with 3 wait states: completes in the watchdog cycle, memory wins
    next_cycle();
    d_valid = 1'b1; d_we = 1'b1; d_wstrb = 4'b0011; d_addr = 32'h400; d_wdata = 32'h1234;
    next_cycle();
    serve(3, 1'b1, 32'h5555_AAAA, 1'b0);

    // Dead address: watchdog fires, late acknowledge in idle is ignored
    if_valid = 1'b1; if_addr = 32'h500;
    next_cycle();
    serve(100, 1'b0, 32'h0, 1'b1);
    next_cycle();
    mem_ready = 1'b0;
    check_idle("late ack");

    // Fetch acknowledged in the watchdog cycle
    if_valid = 1'b1; if_addr = 32'h580;
    next_cycle();
    serve(MAX_WAIT - 1, 1'b0, 32'hCAFE_F00D, 1'b0);

    // Reset in the 2nd cycle of a load; last-grant returns to fetch
    d_valid = 1'b1; d_we = 1'b0; d_wstrb = 4'b1111; d_addr = 32'h600; d_wdata = '0;
    next_cycle();
    mem_ready = 1'b0;
    #1;
    check("load mem_valid", mem_valid, 1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    if_valid = 1'b1; if_addr = 32'h700;
    #1;
    check_idle("mid reset");
    check("mid reset mem_addr", mem_addr, 0);
    check("mid reset mem_wstrb", mem_wstrb, 0);
    check("mid reset d_rdata", d_rdata, 0);
    next_cycle();
    serve(1, 1'b1, 32'h7777_0000, 1'b0);
    last_d = 1'b1;

    // Randomized traffic against the round-robin / latency model
    for (int n = 0; n < 250; n++) begin
      if (!if_valid && $urandom_range(0, 2) != 0) begin
        if_valid = 1'b1;
        if_addr  = $urandom;
      end
      if (!d_valid && $urandom_range(0, 2) != 0) begin
        d_valid = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_wstrb = 4'($urandom_range(0, 15));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      if (!if_valid && !d_valid) begin
        next_cycle();
        check_idle("rand idle");
        continue;
      end
      win_d  = d_valid && (!if_valid || !last_d);
      last_d = win_d;
      next_cycle();
      serve(int'($urandom_range(0, 6)), win_d, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between the instruction-fetch stage and the load/store stage of the pipeline. Accepts one request at a time from each side over valid/ready handshakes, grants the port with round-robin priority when both compete, holds the memory request stable until the memory acknowledges it, and routes read data back to the winner. A wait-state watchdog terminates hung accesses with an error flag, so the core never deadlocks on a dead address.

## Interface
- `MAX_WAIT`, 16: maximum cycles a granted access may wait for `mem_ready` before a timeout. Minimum legal value is 1.
- `ERR_RDATA`, 32'h00000013: read data returned on timeout (a NOP, so a hung fetch degrades safely).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `if_valid` in 1: fetch request.
- `if_addr` in 32: fetch address.
- `if_ready` out 1: fetch complete; one-cycle pulse.
- `if_rdata` out 32: fetch data; valid only while `if_ready` is high.
- `d_valid` in 1: data request.
- `d_we` in 1: 1 = store.
- `d_wstrb` in 4: byte enables for a store.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_ready` out 1: data access complete; one-cycle pulse.
- `d_rdata` out 32: load data; valid only while `d_ready` is high.
- `mem_valid` out 1: memory request.
- `mem_we` out 1: store qualifier.
- `mem_wstrb` out 4: byte enables.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: store data.
- `mem_rdata` in 32: memory read data.
- `mem_ready` in 1: memory acknowledge.
- `err` out 1: one-cycle pulse, coincident with the `if_ready`/`d_ready` pulse of a timed-out access.

## Operation
- FSM states: `IDLE`, `BUSY_IF`, `BUSY_D`.
- In `IDLE`, `valid` inputs are sampled. If only one side requests, that side is granted. If both request, the side that was **not** granted last time wins. After reset, "last grant" = fetch, so data wins the first tie.
- On grant, the requester's address, `we`, `wstrb` and `wdata` are captured into registers that drive the `mem_*` outputs. `mem_valid` rises at the same edge.
- For fetches, `mem_we` and `mem_wstrb` are 0.
- Requesters must hold `valid` and their payload stable until they see `ready`. The arbiter does not re-sample the payload while busy.
- In `BUSY_*`, when `mem_ready` is high:
  - pulse the owner's `ready`;
  - pass `mem_rdata` straight through to the owner's `rdata` (combinational);
  - clear `mem_valid`;
  - return to `IDLE`.
- A wait counter clears on grant and increments each `BUSY` cycle without `mem_ready`. If it reaches `MAX_WAIT`:
  - pulse the owner's `ready` and `err`;
  - drive `rdata` = `ERR_RDATA` (stores are simply dropped);
  - return to `IDLE`.
- `mem_ready` in `IDLE` is ignored. This covers late acknowledges after a timeout.
- Reset values: `mem_valid`=0, `mem_we`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0, `if_ready`=0, `d_ready`=0, `err`=0, `rdata` outputs=0. State = `IDLE`, last-grant = fetch.
- Reset mid-access: state returns to `IDLE` and `mem_valid` drops at that edge. The in-flight access is abandoned and no `ready` is issued for it.

## Timing
- Request seen high at edge N → `mem_valid` high from edge N. With a zero-wait memory (`mem_ready` high in the first `BUSY` cycle), `ready` pulses in that same cycle, giving 1-cycle latency.
- Back-to-back: the `IDLE` cycle after each completion is mandatory, so sustained throughput is one access per 2 cycles with zero-wait memory. No requester is starved: under continuous contention, grants alternate.
- Timeout: `ready` + `err` fire in `BUSY` cycle `MAX_WAIT` (1-based), when no `mem_ready` has arrived earlier. If `mem_ready` coincides with the timeout cycle, `mem_ready` wins and `err`=0.
- The wait counter is `$clog2(MAX_WAIT+1)` bits wide and saturates. It never wraps.

## Structure
- Shared pipeline package holds:
  - the FSM state enum (`ARB_IDLE`, `ARB_BUSY_IF`, `ARB_BUSY_D`);
  - the NOP constant used as the default `ERR_RDATA`;
  - the memory-request bundle typedef (`we`, `wstrb`, `addr`, `wdata`).
- One sub-module, `rr_pick2`: a 2-input round-robin picker with a last-grant register and a `grant` one-hot output. It is reused later for multi-master buses.

## Test plan
- Fetch only, zero-wait memory: `if_addr`=0x100, `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100, `if_ready` pulses with `if_rdata`=0xDEADBEEF, 1-cycle latency, `mem_we`=0.
- Simultaneous `if_valid` and `d_valid`, held continuously → grant order data, fetch, data, fetch. Each `ready` pulses once per grant.
- Store with 3 wait states, `d_wstrb`=4'b0011, `d_wdata`=0x1234 → `mem_*` fields stable for 4 cycles, `d_ready` on cycle 4, `err`=0.
- `MAX_WAIT`=4 with memory never ready → on the 4th `BUSY` cycle, `if_ready`=1, `err`=1, `if_rdata`=0x00000013. A late `mem_ready` in the following `IDLE` is ignored.
- `mem_ready` and the timeout in the same cycle → normal completion, `err`=0.
- `rst` asserted in the 2nd cycle of a load → `mem_valid`=0 and no `d_ready` at the next edge, and all outputs at reset values. The next tie after reset is granted to data.
